// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative multiply/divide unit owning the architectural HI/LO pair.
// Multiplies use shift-add, divides use restoring shift-subtract on operand
// magnitudes; the sign is applied in a final FIX cycle before HI/LO update.
module mdu_hilo #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] mf_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 busy_q;
    logic                 done_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;
    // Mult: {partial product, multiplier}. Div: {remainder, dividend/quotient}.
    logic [2*WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]     opnd_q;     // |multiplicand| or |divisor|
    logic                 is_div_q;
    logic                 neg_q;      // negate product / quotient
    logic                 neg_rem_q;  // negate remainder (dividend sign)
    logic                 divz_q;     // divisor was zero

    // Operand decode for a new request: magnitudes and signs
    logic                 sgn_op;
    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;

    // Single iteration step for the current operation
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_part;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_diff;
    logic [2*WIDTH-1:0]   step_d;

    // Sign-corrected results written in FIX
    logic [2*WIDTH-1:0]   prod_d;
    logic [WIDTH-1:0]     res_hi_d;
    logic [WIDTH-1:0]     res_lo_d;

    // Decode operand signs and magnitudes (unsigned ops pass raw values)
    always_comb begin
        sgn_op = ~op[0];
        a_neg  = sgn_op & a[WIDTH-1];
        b_neg  = sgn_op & b[WIDTH-1];
        a_mag  = a_neg ? -a : a;
        b_mag  = b_neg ? -b : b;
    end

    // One shift-add or restoring shift-subtract step per RUN cycle
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_part = acc_q[2*WIDTH-1:WIDTH-1];
        div_ge   = div_part >= {1'b0, opnd_q};
        div_diff = div_part[WIDTH-1:0] - opnd_q;
        if (is_div_q)
            step_d = {(div_ge ? div_diff : div_part[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
        else
            step_d = {mul_sum, acc_q[WIDTH-1:1]};
    end

    // Sign correction of the magnitude result; divide-by-zero forces LO to ones
    // while HI naturally ends as the sign-restored dividend.
    always_comb begin
        prod_d = neg_q ? -acc_q : acc_q;
        if (is_div_q) begin
            res_lo_d = divz_q ? '1 : (neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
            res_hi_d = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        end else begin
            res_lo_d = prod_d[WIDTH-1:0];
            res_hi_d = prod_d[2*WIDTH-1:WIDTH];
        end
    end

    // Control FSM with HI/LO and datapath registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            divz_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        if (!op[2]) begin
                            acc_q     <= {{WIDTH{1'b0}}, a_mag};
                            opnd_q    <= b_mag;
                            is_div_q  <= op[1];
                            neg_q     <= a_neg ^ b_neg;
                            neg_rem_q <= a_neg;
                            divz_q    <= op[1] & (b == '0);
                            cnt_q     <= CNT_W'(WIDTH);
                            busy_q    <= 1'b1;
                            state_q   <= S_RUN;
                        end else if (op == 3'd4) begin
                            hi_q <= a;
                        end else if (op == 3'd5) begin
                            lo_q <= a;
                        end
                    end
                end
                S_RUN: begin
                    acc_q <= step_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1))
                        state_q <= S_FIX;
                end
                S_FIX: begin
                    hi_q    <= res_hi_d;
                    lo_q    <= res_lo_d;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // HI/LO read port for MFHI/MFLO
    always_comb begin
        case (op)
            3'd6:    mf_data = hi_q;
            3'd7:    mf_data = lo_q;
            default: mf_data = '0;
        endcase
    end

    assign stall = req & busy_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed bench for mdu_hilo: 32-bit instance plus an 8-bit instance.
module tb_mdu_hilo;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        stall, busy, done;
    logic [31:0] hi, lo, mf_data;

    logic        req8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8;
    logic        stall8, busy8, done8;
    logic [7:0]  hi8, lo8, mf_data8;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    int          lat_edges;
    int          lat_busy;
    int          stall_cnt;

    always #5 clk = ~clk;

    mdu_hilo #(.WIDTH(32)) dut (
        .clk(clk), .resetn(resetn), .req(req), .op(op), .a(a), .b(b),
        .stall(stall), .busy(busy), .done(done), .hi(hi), .lo(lo), .mf_data(mf_data)
    );

    mdu_hilo #(.WIDTH(8)) dut8 (
        .clk(clk), .resetn(resetn), .req(req8), .op(op8), .a(a8), .b(b8),
        .stall(stall8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .mf_data(mf_data8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one mult/div at a negedge and wait (bounded) for done.
    // Accept edge counts as edge 1; done must be seen after edge 34.
    task automatic run32(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input string tag);
        req = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        req = 1'b0;
        lat_edges = 1;
        lat_busy  = 0;
        while (done !== 1'b1 && lat_edges < 100) begin
            if (busy === 1'b1) lat_busy++;
            @(negedge clk);
            lat_edges++;
        end
        chk({tag, "_latency"}, 64'(lat_edges), 64'd34);
        chk({tag, "_busycyc"}, 64'(lat_busy), 64'd33);
    endtask

    initial begin
        resetn = 1'b0;
        req = 1'b0; op = 3'd0; a = '0; b = '0;
        req8 = 1'b0; op8 = 3'd0; a8 = '0; b8 = '0;
        @(negedge clk);
        req = 1'b1; op = 3'd0;
        #1;
        chk("rst_busy",  64'(busy),  64'd0);
        chk("rst_done",  64'(done),  64'd0);
        chk("rst_hi",    64'(hi),    64'd0);
        chk("rst_lo",    64'(lo),    64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        req = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        run32(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max");
        chk("multu_max_hi", 64'(hi), 64'hFFFFFFFE);
        chk("multu_max_lo", 64'(lo), 64'h00000001);

        run32(3'd0, 32'hFFFFFFFD, 32'd7, "mult_neg");
        chk("mult_neg_hi", 64'(hi), 64'hFFFFFFFF);
        chk("mult_neg_lo", 64'(lo), 64'hFFFFFFEB);

        run32(3'd2, 32'hFFFFFFF9, 32'd2, "div_neg");
        chk("div_neg_lo", 64'(lo), 64'hFFFFFFFD);
        chk("div_neg_hi", 64'(hi), 64'hFFFFFFFF);

        run32(3'd2, 32'd7, 32'hFFFFFFFE, "div_negb");
        chk("div_negb_lo", 64'(lo), 64'hFFFFFFFD);
        chk("div_negb_hi", 64'(hi), 64'h00000001);

        run32(3'd3, 32'h12345678, 32'd0, "divu_z");
        chk("divu_z_lo", 64'(lo), 64'hFFFFFFFF);
        chk("divu_z_hi", 64'(hi), 64'h12345678);

        run32(3'd2, 32'hFFFFFFFB, 32'd0, "div_z");
        chk("div_z_lo", 64'(lo), 64'hFFFFFFFF);
        chk("div_z_hi", 64'(hi), 64'hFFFFFFFB);

        run32(3'd2, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
        chk("div_ovf_lo", 64'(lo), 64'h80000000);
        chk("div_ovf_hi", 64'(hi), 64'h00000000);

        // MULTU 6*7 followed by an MFLO held in ID: stalled while busy
        req = 1'b1; op = 3'd1; a = 32'd6; b = 32'd7;
        @(negedge clk);
        op = 3'd7;
        lat_edges = 1;
        stall_cnt = 0;
        while (done !== 1'b1 && lat_edges < 100) begin
            if (stall === 1'b1) stall_cnt++;
            @(negedge clk);
            lat_edges++;
        end
        chk("mflo_stallcyc", 64'(stall_cnt), 64'd33);
        chk("mflo_done_stall", 64'(stall), 64'd0);
        chk("mflo_done_data", 64'(mf_data), 64'd42);
        req = 1'b0;
        @(negedge clk);

        // MTHI then MFHI: single cycle, never busy
        req = 1'b1; op = 3'd4; a = 32'hDEADBEEF;
        @(negedge clk);
        op = 3'd6; a = '0;
        #1;
        chk("mfhi_data", 64'(mf_data), 64'hDEADBEEF);
        chk("mthi_busy", 64'(busy), 64'd0);
        chk("mthi_done", 64'(done), 64'd0);
        @(negedge clk);
        chk("mfhi_busy", 64'(busy), 64'd0);
        op = 3'd5; a = 32'h0BADF00D;
        @(negedge clk);
        op = 3'd7; a = '0;
        #1;
        chk("mflo_data", 64'(mf_data), 64'h0BADF00D);
        chk("mflo_hi_kept", 64'(hi), 64'hDEADBEEF);
        op = 3'd0;
        #1;
        chk("mf_other_zero", 64'(mf_data), 64'd0);
        req = 1'b0;
        @(negedge clk);

        run32(3'd3, 32'd100, 32'd7, "divu_100_7");
        chk("divu_100_7_lo", 64'(lo), 64'd14);
        chk("divu_100_7_hi", 64'(hi), 64'd2);

        // Back-to-back: issued in the done cycle of the previous op
        run32(3'd1, 32'd9, 32'd11, "b2b_multu");
        chk("b2b_multu_lo", 64'(lo), 64'd99);
        chk("b2b_multu_hi", 64'(hi), 64'd0);

        // Reset 10 cycles into a DIV
        req = 1'b1; op = 3'd2; a = 32'd1000; b = 32'd3;
        @(negedge clk);
        req = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_rst_busy", 64'(busy), 64'd1);
        resetn = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_hi",   64'(hi),   64'd0);
        chk("midrst_lo",   64'(lo),   64'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("postrst_done", 64'(done), 64'd0);
        run32(3'd1, 32'd3, 32'd5, "multu_3_5");
        chk("multu_3_5_lo", 64'(lo), 64'd15);
        chk("multu_3_5_hi", 64'(hi), 64'd0);

        // WIDTH=8 instance: MULT -128 * -128 = 0x4000, done after 10 edges
        req8 = 1'b1; op8 = 3'd0; a8 = 8'h80; b8 = 8'h80;
        @(negedge clk);
        req8 = 1'b0;
        lat_edges = 1;
        while (done8 !== 1'b1 && lat_edges < 100) begin
            @(negedge clk);
            lat_edges++;
        end
        chk("w8_latency", 64'(lat_edges), 64'd10);
        chk("w8_prod", 64'({hi8, lo8}), 64'h4000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
